// File: rtl/core_pkg.sv
// core_pkg: constants and types shared by the fetch front end.
//   RESET_VEC_DEFAULT : first fetch address after reset
//   fetch_entry_t     : one instruction-queue entry {data, pc}
package core_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_080c;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular instruction queue of fetch_entry_t.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   clr_i          : synchronous clear (wins over push/pop)
//   push_i/data_i  : write an entry (accepted when not full, or full with pop)
//   pop_i          : drop the head entry
//   head_o         : current head entry
//   empty_o        : queue empty
//   count_o        : occupancy, 0..DEPTH
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    do_push  = push_i && (!full || pop_i);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; on a full push+pop the write slot equals the slot being read out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!clr_i && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  fetch_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .count_i (count_q)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// fetch_fifo_chk: simulation-only protocol checks for fetch_fifo.
// Ports: clk_i, rst_ni, clr_i, push_i, pop_i, count_i (current occupancy).
module fetch_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          clr_i,
  input logic          push_i,
  input logic          pop_i,
  input logic [CW-1:0] count_i
);

  // A push into a full queue is only legal when a pop frees the slot in the same cycle.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && !clr_i && (count_i == CW'(DEPTH))))
    else $error("fetch_fifo overflow");

  // Popping an empty queue means the consumer ignored the valid flag.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && !clr_i && (count_i == {CW{1'b0}})))
    else $error("fetch_fifo underflow");

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction prefetcher with credit-based request issue,
// an in-order response queue and redirect handling with stale-response drop.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   req_valid/req_ready/req_addr   : instruction-memory request channel
//   resp_valid/resp_data           : in-order memory responses (no backpressure)
//   redirect/redirect_pc           : taken branch/jump target from execute
//   inst_valid/inst_ready/inst_data/inst_pc : decode channel
//   perf_fetched/perf_dropped      : performance counters (FETCH_PERF_CNT_EN only)
// Build option: define FETCH_PERF_CNT_EN to add the two performance counters.
module prefetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic          run_q;              // low until the first edge after reset release
  logic [31:0]   fpc_q, fpc_d;       // next address to request
  logic [31:0]   rpc_q, rpc_d;       // pc of the next response to be queued
  logic [CW-1:0] out_q, out_d;       // requests accepted but not yet answered
  logic [CW-1:0] drop_q, drop_d;     // responses still to be discarded after a redirect
  logic [CW-1:0] occ;
  logic          fifo_empty;
  logic          req_fire;
  logic          dropping;
  logic          push;
  logic          pop;
  logic          discard;
  logic [31:0]   target;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Issue credit: queued entries plus in-flight requests never exceed the queue depth.
  always_comb begin
    req_valid  = run_q && !redirect && (({1'b0, occ} + {1'b0, out_q}) < DEPTH_W);
    req_addr   = fpc_q;
    req_fire   = req_valid && req_ready;
    dropping   = (drop_q != {CW{1'b0}});
    push       = resp_valid && !redirect && !dropping;
    discard    = resp_valid && (redirect || dropping);
    inst_valid = !fifo_empty;
    inst_data  = head.data;
    inst_pc    = head.pc;
    pop        = inst_valid && inst_ready;
    target     = redirect_pc & 32'hffff_fffc;
    push_entry = '{data: resp_data, pc: rpc_q};
  end

  // Next-state for fetch pc, response pc, outstanding and drop counters.
  always_comb begin
    fpc_d  = fpc_q;
    rpc_d  = rpc_q;
    drop_d = drop_q;
    case ({req_fire, resp_valid})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    if (redirect) begin
      // Everything still in flight belongs to the old path; the response arriving
      // now is discarded directly, so it is not counted again.
      fpc_d  = target;
      rpc_d  = target;
      drop_d = resp_valid ? (out_q - CW'(1)) : out_q;
    end else begin
      if (req_fire) fpc_d = fpc_q + 32'd4;
      if (push)     rpc_d = rpc_q + 32'd4;
      if (resp_valid && dropping) drop_d = drop_q - CW'(1);
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      fpc_q  <= RESET_VEC;
      rpc_q  <= RESET_VEC;
      out_q  <= {CW{1'b0}};
      drop_q <= {CW{1'b0}};
    end else begin
      run_q  <= 1'b1;
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (redirect),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .count_o (occ)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] dropped_q;

  // Delivered-instruction and discarded-response counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= 32'd0;
      dropped_q <= 32'd0;
    end else begin
      fetched_q <= fetched_q + {31'd0, pop};
      dropped_q <= dropped_q + {31'd0, discard};
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed self-checking bench for prefetch_unit.
// A fixed-latency in-order memory model answers every accepted request with
// mdata(addr); tests drive inputs on the falling edge and sample 3 time units later.
module tb_prefetch_unit;

  localparam logic [31:0] RV = 32'h8000_080c;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int cyc      = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];

  prefetch_unit #(.RESET_VEC(32'h8000_080c), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  // Memory model: responses mem_lat cycles after acceptance (1 = next cycle).
  initial begin
    resp_valid = 1'b0;
    resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mq_addr.delete();
        mq_due.delete();
        resp_valid = 1'b0;
      end else if (mq_due.size() > 0 && mq_due[0] == cyc) begin
        resp_valid = 1'b1;
        resp_data  = mdata(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        resp_valid = 1'b0;
      end
      #2;
      if (rst_n && req_valid && req_ready) begin
        mq_addr.push_back(req_addr);
        mq_due.push_back(cyc + mem_lat);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    #3;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    n_checks++; if (req_addr !== RV) begin n_fail++; $display("FAIL reset_req_addr: got %h want %h", req_addr, RV); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if ({perf_fetched, perf_dropped} !== 64'd0) begin n_fail++; $display("FAIL reset_perf: got %h %h want 0 0", perf_fetched, perf_dropped); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL release_no_early_req: got %b want 0", req_valid); end
    @(negedge clk); #3;
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL release_first_req: got %b want 1", req_valid); end
  endtask

  // Runs ncyc cycles of free streaming from RV and checks request/instruction order.
  task automatic run_stream(input string tag, input int ncyc);
    logic [31:0] exp_req = RV;
    logic [31:0] exp_inst = RV;
    int first_req = -1, first_inst = -1, ndel = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk); #3;
      if (req_valid && req_ready) begin
        if (first_req < 0) first_req = c;
        n_checks++; if (req_addr !== exp_req) begin n_fail++; $display("FAIL %s_req_addr: got %h want %h", tag, req_addr, exp_req); end
        exp_req += 32'd4;
      end
      if (inst_valid) begin
        if (first_inst < 0) first_inst = c;
        n_checks++; if ({inst_pc, inst_data} !== {exp_inst, mdata(exp_inst)}) begin n_fail++; $display("FAIL %s_inst: got %h/%h want %h/%h", tag, inst_pc, inst_data, exp_inst, mdata(exp_inst)); end
        exp_inst += 32'd4;
        ndel++;
      end
    end
    n_checks++; if (first_req !== 0) begin n_fail++; $display("FAIL %s_first_req_cycle: got %0d want 0", tag, first_req); end
    n_checks++; if (first_inst !== 2) begin n_fail++; $display("FAIL %s_first_inst_cycle: got %0d want 2", tag, first_inst); end
    n_checks++; if (ndel !== ncyc - 2) begin n_fail++; $display("FAIL %s_delivered: got %0d want %0d", tag, ndel, ncyc - 2); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if (perf_fetched !== 32'(ncyc - 3)) begin n_fail++; $display("FAIL %s_perf_fetched: got %0d want %0d", tag, perf_fetched, ncyc - 3); end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    run_stream("stream", 20);
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset();
    mem_lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #3;
      if (req_valid && req_ready) nreq++;
      if (c >= 2) begin
        n_checks++; if ({inst_valid, inst_pc} !== {1'b1, RV}) begin n_fail++; $display("FAIL bp_head_stable: got %b/%h want 1/%h", inst_valid, inst_pc, RV); end
      end
    end
    n_checks++; if (nreq !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", nreq); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_blocked: got %b want 0", req_valid); end
    @(negedge clk); inst_ready = 1'b1; #3;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_in_pop_cycle: got %b want 0", req_valid); end
    @(negedge clk); inst_ready = 1'b0; #3;
    n_checks++; if ({req_valid, req_addr} !== {1'b1, RV + 32'd16}) begin n_fail++; $display("FAIL bp_reenabled_req: got %b/%h want 1/%h", req_valid, req_addr, RV + 32'd16); end
    n_checks++; if ({inst_pc, inst_data} !== {RV + 32'd4, mdata(RV + 32'd4)}) begin n_fail++; $display("FAIL bp_head_after_pop: got %h/%h", inst_pc, inst_data); end
    nreq = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #3;
      if (req_valid && req_ready) nreq++;
    end
    n_checks++; if (nreq !== 1) begin n_fail++; $display("FAIL bp_one_credit: got %0d requests want 1", nreq); end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] exp = 32'h8000_1000;
    int nacc = 0, rcyc = -1, first = -1;
    do_reset();
    mem_lat = 4; req_ready = 1'b1; inst_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (nacc == 3 && rcyc < 0) begin
        redirect = 1'b1; redirect_pc = 32'h8000_1002; rcyc = c;
      end else begin
        redirect = 1'b0;
      end
      #3;
      if (c == rcyc) begin
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_req_masked: got %b want 0", req_valid); end
      end
      if (rcyc >= 0 && c == rcyc + 1) begin
        n_checks++; if ({req_valid, req_addr} !== {1'b1, 32'h8000_1000}) begin n_fail++; $display("FAIL rd_target_req: got %b/%h want 1/80001000", req_valid, req_addr); end
      end
      if (req_valid && req_ready) nacc++;
      if (inst_valid) begin
        if (first < 0) first = c;
        n_checks++; if ({inst_pc, inst_data} !== {exp, mdata(exp)}) begin n_fail++; $display("FAIL rd_inst: got %h/%h want %h/%h", inst_pc, inst_data, exp, mdata(exp)); end
        exp += 32'd4;
      end
    end
    n_checks++; if (rcyc !== 3 || first !== rcyc + 6) begin n_fail++; $display("FAIL rd_first_inst_cycle: got %0d want %0d", first, rcyc + 6); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if (perf_dropped !== 32'd3) begin n_fail++; $display("FAIL rd_perf_dropped: got %0d want 3", perf_dropped); end
`endif
  endtask

  // Redirect in a cycle that also carries a response and a pop.
  task automatic test_redirect_hit(input int lat, input logic [31:0] tgt);
    logic [31:0] exp = tgt;
    int first = -1;
    do_reset();
    mem_lat = lat; req_ready = 1'b1; inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    @(negedge clk); redirect = 1'b1; redirect_pc = tgt; #3;
    n_checks++; if ({resp_valid, inst_valid, req_valid} !== 3'b110) begin n_fail++; $display("FAIL hit%0d_redirect_cycle: got resp/inst/req %b%b%b want 110", lat, resp_valid, inst_valid, req_valid); end
    @(negedge clk); redirect = 1'b0; #3;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL hit%0d_queue_cleared: got %b want 0", lat, inst_valid); end
    n_checks++; if ({req_valid, req_addr} !== {1'b1, tgt}) begin n_fail++; $display("FAIL hit%0d_target_req: got %b/%h want 1/%h", lat, req_valid, req_addr, tgt); end
    for (int k = 2; k < 12; k++) begin
      @(negedge clk); #3;
      if (inst_valid) begin
        if (first < 0) first = k;
        n_checks++; if ({inst_pc, inst_data} !== {exp, mdata(exp)}) begin n_fail++; $display("FAIL hit%0d_inst: got %h/%h want %h/%h", lat, inst_pc, inst_data, exp, mdata(exp)); end
        exp += 32'd4;
      end
    end
    n_checks++; if (first !== lat + 2) begin n_fail++; $display("FAIL hit%0d_latency: got %0d want %0d", lat, first, lat + 2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp = 32'h8000_3000;
    int ndel = 0, bad = 0;
    do_reset();
    mem_lat = 2; req_ready = 1'b1; inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h8000_2000;
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h8000_3000; #3;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_first_target_req: got %b want 0", req_valid); end
    @(negedge clk); redirect = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      if (inst_valid) begin
        if (inst_pc === 32'h8000_2000) bad++;
        n_checks++; if ({inst_pc, inst_data} !== {exp, mdata(exp)}) begin n_fail++; $display("FAIL b2b_inst: got %h/%h want %h/%h", inst_pc, inst_data, exp, mdata(exp)); end
        exp += 32'd4;
        ndel++;
      end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_stale_target: got %0d deliveries tagged 80002000 want 0", bad); end
    n_checks++; if (ndel !== 11) begin n_fail++; $display("FAIL b2b_delivered: got %0d want 11", ndel); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({req_valid, inst_valid} !== 2'b00) begin n_fail++; $display("FAIL async_rst_valids: got %b%b want 00", req_valid, inst_valid); end
    n_checks++; if (req_addr !== RV) begin n_fail++; $display("FAIL async_rst_addr: got %h want %h", req_addr, RV); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if ({perf_fetched, perf_dropped} !== 64'd0) begin n_fail++; $display("FAIL async_rst_perf: got %h %h want 0 0", perf_fetched, perf_dropped); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_stream("after_rst", 10);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_hit(1, 32'h8000_4000);
    test_redirect_hit(2, 32'h8000_5008);
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
